// File: rtl/q2_i2c_pkg.sv
// q2_i2c_pkg: shared types and constants for the q2 CPU-side I2C master.
//   - op codes of the 12-bit command word [11:10]
//   - bus-sequencer state encoding
//   - status word bit positions
//   - bit_sda(): SDA level to drive during a given bit of a BYTE command
package q2_i2c_pkg;

    localparam int unsigned DATA_W    = 12;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned BIT_CNT_W = 4;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_STOP  = 2'b10;
    localparam logic [1:0] OP_BYTE  = 2'b11;

    localparam int unsigned ST_BUSY = 11;
    localparam int unsigned ST_ACK  = 10;
    localparam int unsigned ST_OVF  = 9;

    // Bit index of the ACK slot within a BYTE transfer
    localparam logic [BIT_CNT_W-1:0] ACK_BIT = BIT_CNT_W'(8);

    typedef enum logic [3:0] {
        IDLE,
        S0, S1, S2,
        B0, B1, B2, B3,
        P0, P1, P2
    } state_e;

    // Command word layout
    typedef struct packed {
        logic [1:0]        op;
        logic              dir;
        logic              mack;
        logic [BYTE_W-1:0] wdata;
    } cmd_t;

    // Data bits go MSB first; reads release SDA for data and drive the
    // master ACK/NACK in the ACK slot, writes release SDA in the ACK slot.
    function automatic logic bit_sda(input logic dir, input logic mack,
                                     input logic [BYTE_W-1:0] wdata,
                                     input logic [BIT_CNT_W-1:0] idx);
        logic v;
        if (idx >= ACK_BIT) begin
            v = dir ? mack : 1'b1;
        end else begin
            v = dir ? 1'b1 : wdata[3'(BIT_CNT_W'(7) - idx)];
        end
        return v;
    endfunction

endpackage

// File: rtl/q2_i2c_tick.sv
// q2_i2c_tick: quarter-bit divider for the I2C master.
//   clk, rst_n : clock, async active-low reset
//   en_i       : count enable (busy and not stretched)
//   clr_i      : synchronous clear to 0 (command accept)
//   tick_c_o   : one-clk tick when the enabled counter is at DIV-1
module q2_i2c_tick #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_c_o
);

    localparam int unsigned     CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    // Wrapping divider counter, frozen when not enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign tick_c_o = en_i && (cnt_q == CNT_MAX);

endmodule

// File: rtl/q2_i2c_master.sv
// q2_i2c_master: CPU-side I2C master on the q2 12-bit data bus.
//   clk, rst_n  : clock, async active-low reset (releases both lines at once)
//   wr, data_in : command strobe and word {op[1:0], dir, mack, wdata[7:0]}
//   rd          : status read strobe, clears the sticky overflow flag
//   data_out    : status {busy, ack, ovf, 0, rdata[7:0]}
//   i2c_sda_in  : sampled SDA
//   i2c_scl_in  : sampled SCL, used only when Q2_I2C_CLOCK_STRETCH_EN is defined
//   i2c_scl_out, i2c_sda_out : line drives, 1 = released
// Optional build macro: Q2_I2C_CLOCK_STRETCH_EN (hold B1/P1 until SCL reads high).
module q2_i2c_master
    import q2_i2c_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic              rd,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    input  logic              i2c_sda_in,
    input  logic              i2c_scl_in,
    output logic              i2c_scl_out,
    output logic              i2c_sda_out
);

    state_e               state_q;
    logic                 busy_q;
    logic                 ack_q;
    logic                 ovf_q;
    logic [BYTE_W-1:0]    rdata_q;
    logic [BYTE_W-1:0]    wdata_q;
    logic                 dir_q;
    logic                 mack_q;
    logic [BIT_CNT_W-1:0] bit_q;
    logic                 scl_q;
    logic                 sda_q;

    cmd_t cmd_in_c;
    logic accept_c;
    logic drop_c;
    logic hold_c;
    logic tick_en_c;
    logic tick_c;

    assign cmd_in_c = cmd_t'(data_in);
    assign accept_c = wr && !busy_q && (cmd_in_c.op != OP_NOP);
    assign drop_c   = wr && busy_q;

    // Slave clock stretching: freeze the sequencer while SCL is held low
`ifdef Q2_I2C_CLOCK_STRETCH_EN
    assign hold_c = ((state_q == B1) || (state_q == P1)) && !i2c_scl_in;
`else
    logic unused_scl_in;
    assign unused_scl_in = i2c_scl_in;
    assign hold_c        = 1'b0;
`endif

    assign tick_en_c = busy_q && !hold_c;

    q2_i2c_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (tick_en_c),
        .clr_i    (accept_c),
        .tick_c_o (tick_c)
    );

    // Bus sequencer; line levels are registered on entry to each state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            ovf_q   <= 1'b0;
            rdata_q <= '0;
            wdata_q <= '0;
            dir_q   <= 1'b0;
            mack_q  <= 1'b0;
            bit_q   <= '0;
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
        end else begin
            if (accept_c) begin
                busy_q  <= 1'b1;
                bit_q   <= '0;
                wdata_q <= cmd_in_c.wdata;
                dir_q   <= cmd_in_c.dir;
                mack_q  <= cmd_in_c.mack;
                case (cmd_in_c.op)
                    OP_START: begin
                        state_q <= S0;
                        scl_q   <= 1'b1;
                        sda_q   <= 1'b1;
                    end
                    OP_STOP: begin
                        state_q <= P0;
                        scl_q   <= 1'b0;
                        sda_q   <= 1'b0;
                    end
                    default: begin
                        state_q <= B0;
                        scl_q   <= 1'b0;
                        sda_q   <= bit_sda(cmd_in_c.dir, cmd_in_c.mack,
                                           cmd_in_c.wdata, '0);
                    end
                endcase
            end else if (tick_c) begin
                case (state_q)
                    S0: begin
                        state_q <= S1;
                        sda_q   <= 1'b0;
                    end
                    S1: begin
                        state_q <= S2;
                        scl_q   <= 1'b0;
                    end
                    S2: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                    B0: begin
                        state_q <= B1;
                        scl_q   <= 1'b1;
                    end
                    B1: begin
                        state_q <= B2;
                    end
                    B2: begin
                        // Sample mid-high: read data shifts in, a write's ACK slot loads ack
                        state_q <= B3;
                        if (bit_q == ACK_BIT) begin
                            if (!dir_q) begin
                                ack_q <= i2c_sda_in;
                            end
                        end else if (dir_q) begin
                            rdata_q <= {rdata_q[BYTE_W-2:0], i2c_sda_in};
                        end
                    end
                    B3: begin
                        if (bit_q == ACK_BIT) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            sda_q   <= 1'b1;
                        end else begin
                            state_q <= B0;
                            bit_q   <= bit_q + BIT_CNT_W'(1);
                            sda_q   <= bit_sda(dir_q, mack_q, wdata_q,
                                               bit_q + BIT_CNT_W'(1));
                        end
                        scl_q <= 1'b0;
                    end
                    P0: begin
                        state_q <= P1;
                        scl_q   <= 1'b1;
                    end
                    P1: begin
                        state_q <= P2;
                        sda_q   <= 1'b1;
                    end
                    P2: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end

            // Sticky overflow: a dropped command outranks a same-cycle read clear
            if (drop_c) begin
                ovf_q <= 1'b1;
            end else if (rd) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // Status word assembled from registers
    always_comb begin
        data_out          = '0;
        data_out[ST_BUSY] = busy_q;
        data_out[ST_ACK]  = ack_q;
        data_out[ST_OVF]  = ovf_q;
        data_out[7:0]     = rdata_q;
    end

    assign i2c_scl_out = scl_q;
    assign i2c_sda_out = sda_q;

endmodule

// File: tb/tb_q2_i2c_master.sv
// tb_q2_i2c_master: directed bench for q2_i2c_master with DIV=4.
// Table vectors cover START/STOP sequencing and overflow handling; hand
// sequences cover byte transfers, reset mid-byte and optional clock stretch.
module tb_q2_i2c_master;

    logic        clk;
    logic        rst_n = 1'b0;
    logic        wr;
    logic        rd;
    logic [11:0] data_in;
    logic [11:0] data_out;
    logic        sda_in;
    logic        scl_in;
    logic        scl_out;
    logic        sda_out;

    int n_vec = 0;
    int n_err = 0;

    // Bus monitor: shift SDA on every SCL rise
    logic [8:0] mon_sh  = '0;
    int         mon_cnt = 0;

    q2_i2c_master #(
        .DIV (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr          (wr),
        .rd          (rd),
        .data_in     (data_in),
        .data_out    (data_out),
        .i2c_sda_in  (sda_in),
        .i2c_scl_in  (scl_in),
        .i2c_scl_out (scl_out),
        .i2c_sda_out (sda_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge scl_out) begin
        mon_sh  <= {mon_sh[7:0], sda_out};
        mon_cnt <= mon_cnt + 1;
    end

    typedef struct {
        logic        wr;
        logic        rd;
        logic [11:0] din;
        int          n;
        logic [11:0] dout;
        logic        scl;
        logic        sda;
    } vec_t;

    vec_t vt[16];

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%03h expected 0x%03h", name, act, exp);
        end
    endtask

    // Apply inputs for one edge, wait until n edges have passed, compare
    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            wr      = vt[i].wr;
            rd      = vt[i].rd;
            data_in = vt[i].din;
            @(negedge clk);
            wr = 1'b0;
            rd = 1'b0;
            repeat (vt[i].n - 1) @(negedge clk);
            check($sformatf("vec%0d data_out", i), data_out, vt[i].dout);
            check($sformatf("vec%0d scl", i), 12'(scl_out), 12'(vt[i].scl));
            check($sformatf("vec%0d sda", i), 12'(sda_out), 12'(vt[i].sda));
        end
    endtask

    // One BYTE command; sin[8-k] is what the slave presents during bit k
    task automatic run_byte(input logic [11:0] cmd, input logic [8:0] sin,
                            input logic [11:0] exp_dout, input logic [7:0] exp_byte,
                            input logic exp_ackslot);
        int c0;
        c0      = mon_cnt;
        wr      = 1'b1;
        data_in = cmd;
        for (int k = 0; k < 9; k++) begin
            sda_in = sin[8-k];
            repeat (16) begin
                @(negedge clk);
                wr = 1'b0;
            end
        end
        check("byte busy at 143", 12'(data_out[11]), 12'd1);
        @(negedge clk);
        check("byte status at 144", data_out, exp_dout);
        check("byte scl rises", 12'(mon_cnt - c0), 12'd9);
        check("byte on wire", 12'(mon_sh[8:1]), 12'(exp_byte));
        check("byte ack slot sda", 12'(mon_sh[0]), 12'(exp_ackslot));
    endtask

    initial begin
        int changes;

        //            wr    rd    din     n  dout    scl   sda
        vt[0]  = '{1'b1, 1'b0, 12'h400, 1, 12'h800, 1'b1, 1'b1};
        vt[1]  = '{1'b0, 1'b0, 12'h000, 4, 12'h800, 1'b1, 1'b0};
        vt[2]  = '{1'b0, 1'b0, 12'h000, 4, 12'h800, 1'b0, 1'b0};
        vt[3]  = '{1'b0, 1'b0, 12'h000, 3, 12'h800, 1'b0, 1'b0};
        vt[4]  = '{1'b0, 1'b0, 12'h000, 1, 12'h000, 1'b0, 1'b0};
        vt[5]  = '{1'b1, 1'b0, 12'h800, 1, 12'h83C, 1'b0, 1'b0};
        vt[6]  = '{1'b0, 1'b0, 12'h000, 4, 12'h83C, 1'b1, 1'b0};
        vt[7]  = '{1'b0, 1'b0, 12'h000, 4, 12'h83C, 1'b1, 1'b1};
        vt[8]  = '{1'b0, 1'b0, 12'h000, 4, 12'h03C, 1'b1, 1'b1};
        vt[9]  = '{1'b1, 1'b0, 12'h400, 2, 12'h83C, 1'b1, 1'b1};
        vt[10] = '{1'b1, 1'b0, 12'h800, 1, 12'hA3C, 1'b1, 1'b1};
        vt[11] = '{1'b0, 1'b1, 12'h000, 1, 12'h83C, 1'b1, 1'b1};
        vt[12] = '{1'b1, 1'b0, 12'h800, 1, 12'hA3C, 1'b1, 1'b0};
        vt[13] = '{1'b1, 1'b1, 12'h800, 1, 12'hA3C, 1'b1, 1'b0};
        vt[14] = '{1'b0, 1'b1, 12'h000, 1, 12'h83C, 1'b1, 1'b0};
        vt[15] = '{1'b0, 1'b0, 12'h000, 6, 12'h03C, 1'b0, 1'b0};

        wr      = 1'b0;
        rd      = 1'b0;
        data_in = '0;
        sda_in  = 1'b1;
        scl_in  = 1'b1;

        // Reset release and quiet bus
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset data_out", data_out, 12'h000);
        check("reset scl", 12'(scl_out), 12'd1);
        check("reset sda", 12'(sda_out), 12'd1);
        changes = 0;
        repeat (100) begin
            @(negedge clk);
            if (scl_out !== 1'b1 || sda_out !== 1'b1) changes++;
        end
        check("idle line changes", 12'(changes), 12'd0);

        // START
        run_vecs(0, 4);

        // Write 0xA5 with NACK, then with ACK, then read 0x3C with master NACK
        run_byte(12'hCA5, {8'hFF, 1'b1}, 12'h400, 8'hA5, 1'b1);
        run_byte(12'hCA5, {8'h00, 1'b0}, 12'h000, 8'hA5, 1'b1);
        run_byte(12'hF00, {8'h3C, 1'b0}, 12'h03C, 8'hFF, 1'b1);

        // STOP, then overflow set/clear around a START
        sda_in = 1'b1;
        run_vecs(5, 15);

        // Reset in bit 4 of a write byte
        wr      = 1'b1;
        data_in = 12'hCA5;
        sda_in  = 1'b0;
        @(negedge clk);
        wr = 1'b0;
        repeat (65) @(negedge clk);
        check("bit4 scl before reset", 12'(scl_out), 12'd0);
        check("bit4 sda before reset", 12'(sda_out), 12'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async reset scl", 12'(scl_out), 12'd1);
        check("async reset sda", 12'(sda_out), 12'd1);
        check("async reset status", data_out, 12'h000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef Q2_I2C_CLOCK_STRETCH_EN
        // Slave holds SCL low for 50 clk in bit 0 B1; byte ends 50 clk late
        wr      = 1'b1;
        data_in = 12'hCA5;
        sda_in  = 1'b0;
        @(negedge clk);
        wr = 1'b0;
        repeat (3) @(negedge clk);
        scl_in = 1'b0;
        repeat (51) @(negedge clk);
        scl_in = 1'b1;
        repeat (139) @(negedge clk);
        check("stretch busy at 193", data_out, 12'h800);
        @(negedge clk);
        check("stretch done at 194", data_out, 12'h000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
